// File: rtl/cdf53_pkg.sv
// Shared types and constants for the cdf5_3 row sequencer.
//   state_e    : sequencer states
//   DW_DEFAULT : default sample width
//   CORE_LAT   : nominal core latency, pair-in to result (informational)
//   cnt_width  : width of a counter that must hold 0..n without wrapping
package cdf53_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned CORE_LAT   = 2;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/cdf53_row_sequencer_if.sv
// Sample stream, core-side and coefficient-output signals of the row sequencer.
//   slave  : sequencer view (accepts samples, drives core and coefficient outputs)
//   master : environment view (drives samples and core results)
interface cdf53_row_sequencer_if #(
    parameter int unsigned LENGTH = 16,
    parameter int unsigned DW     = cdf53_pkg::DW_DEFAULT
) ();
    localparam int unsigned IW = $clog2(LENGTH);

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;

    logic          core_en;
    logic          core_dis;
    logic [DW-1:0] core_in0;
    logic [DW-1:0] core_in1;
    logic [DW-1:0] core_in2;
    logic [DW-1:0] core_out_s;
    logic [DW-1:0] core_out_d;
    logic          core_result;

    logic          m_valid;
    logic [DW-1:0] m_s;
    logic [DW-1:0] m_d;
    logic [IW-1:0] m_idx;

    modport slave (
        input  s_valid, s_data, core_out_s, core_out_d, core_result,
        output s_ready, core_en, core_dis, core_in0, core_in1, core_in2,
               m_valid, m_s, m_d, m_idx
    );

    modport master (
        output s_valid, s_data, core_out_s, core_out_d, core_result,
        input  s_ready, core_en, core_dis, core_in0, core_in1, core_in2,
               m_valid, m_s, m_d, m_idx
    );

endinterface

// File: rtl/cdf53_row_buf.sv
// Row sample store: LENGTH x DW registers, one write port, three combinational reads.
//   clk, resetn          : clock, async active-low reset
//   we, waddr, wdata     : write port
//   raddr0..2, rdata0..2 : read ports
module cdf53_row_buf #(
    parameter  int unsigned LENGTH = 16,
    parameter  int unsigned DW     = cdf53_pkg::DW_DEFAULT,
    localparam int unsigned AW     = $clog2(LENGTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] mem_q [LENGTH];

    // Storage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(LENGTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/cdf53_row_sequencer.sv
// Row sequencer for an external cdf5_3 lifting core: buffers one row of samples,
// presents (x[2k], x[2k+1], x[2k+2]) triples to the core one per cycle, then
// collects LENGTH/2 core results as indexed coefficient pairs. A FLUSH watchdog
// ends the row with a sticky error if the core stops answering.
//   clk, resetn       : clock, async active-low reset
//   start             : begin a row (honoured in IDLE only)
//   busy, done, err   : status; done pulses once per row, err is sticky
//   bus (slave)       : sample stream in, core drive/return, coefficient stream out
module cdf53_row_sequencer
    import cdf53_pkg::*;
#(
    parameter int unsigned LENGTH = 16,
    parameter int unsigned DW     = DW_DEFAULT,
    parameter int unsigned WD_MAX = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    cdf53_row_sequencer_if.slave  bus
);

    localparam int unsigned AW   = $clog2(LENGTH);
    localparam int unsigned CW   = cnt_width(LENGTH);
    localparam int unsigned PW   = CW + 1;
    localparam int unsigned WW   = cnt_width(WD_MAX);
    localparam int unsigned HALF = LENGTH / 2;

    state_e        state_q;
    logic          busy_q, done_q, err_q, s_ready_q;
    logic          core_en_q, core_dis_q, m_valid_q;
    logic [DW-1:0] in0_q, in1_q, in2_q;
    logic [DW-1:0] m_s_q, m_d_q;
    logic [AW-1:0] m_idx_q;
    logic [CW-1:0] wr_cnt_q, pair_q, res_q;
    logic [WW-1:0] wd_q;

    logic          we;
    logic [CW-1:0] rd_pair;
    logic [AW-1:0] ra0, ra1, ra2;
    logic [DW-1:0] rd0, rd1, rd2;
    logic          collect, last_res, last_pair, wd_expired;

    assign we         = s_ready_q & bus.s_valid;
    assign collect    = bus.core_result & ((state_q == ST_RUN) | (state_q == ST_FLUSH));
    assign last_res   = collect & (res_q == CW'(HALF - 1));
    assign last_pair  = (pair_q == CW'(HALF - 1));
    assign wd_expired = (wd_q == WW'(WD_MAX - 1));

    // Read the pair that will be presented next cycle: pair 0 while loading,
    // pair k+1 while pair k is on the core. The last pair replicates x[LENGTH-1].
    always_comb begin
        rd_pair = '0;
        if (state_q == ST_RUN) begin
            rd_pair = pair_q + CW'(1);
        end
        ra0 = AW'({rd_pair, 1'b0});
        ra1 = AW'({rd_pair, 1'b1});
        if (rd_pair == CW'(HALF - 1)) begin
            ra2 = AW'(LENGTH - 1);
        end else begin
            ra2 = AW'({rd_pair, 1'b0} + PW'(2));
        end
    end

    cdf53_row_buf #(
        .LENGTH (LENGTH),
        .DW     (DW)
    ) u_buf (
        .clk    (clk),
        .resetn (resetn),
        .we     (we),
        .waddr  (wr_cnt_q[AW-1:0]),
        .wdata  (bus.s_data),
        .raddr0 (ra0),
        .raddr1 (ra1),
        .raddr2 (ra2),
        .rdata0 (rd0),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    // Sequencer FSM with registered outputs. busy stays high through the done
    // cycle and falls on the following one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            core_en_q  <= 1'b0;
            core_dis_q <= 1'b0;
            m_valid_q  <= 1'b0;
            in0_q      <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            m_s_q      <= '0;
            m_d_q      <= '0;
            m_idx_q    <= '0;
            wr_cnt_q   <= '0;
            pair_q     <= '0;
            res_q      <= '0;
            wd_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            core_en_q  <= 1'b0;
            core_dis_q <= 1'b0;
            m_valid_q  <= 1'b0;

            if (collect) begin
                m_valid_q <= 1'b1;
                m_s_q     <= bus.core_out_s;
                m_d_q     <= bus.core_out_d;
                m_idx_q   <= AW'(res_q);
                res_q     <= res_q + CW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    busy_q <= start;
                    if (start) begin
                        state_q   <= ST_LOAD;
                        err_q     <= 1'b0;
                        s_ready_q <= 1'b1;
                        wr_cnt_q  <= '0;
                        pair_q    <= '0;
                        res_q     <= '0;
                        wd_q      <= '0;
                    end
                end
                ST_LOAD: begin
                    if (we) begin
                        wr_cnt_q <= wr_cnt_q + CW'(1);
                        if (wr_cnt_q == CW'(LENGTH - 1)) begin
                            state_q   <= ST_RUN;
                            s_ready_q <= 1'b0;
                            core_en_q <= 1'b1;
                            in0_q     <= rd0;
                            in1_q     <= rd1;
                            in2_q     <= rd2;
                        end
                    end
                end
                ST_RUN: begin
                    if (last_pair) begin
                        state_q    <= ST_FLUSH;
                        core_dis_q <= 1'b1;
                        in0_q      <= '0;
                        in1_q      <= '0;
                        in2_q      <= '0;
                        wd_q       <= '0;
                    end else begin
                        pair_q <= pair_q + CW'(1);
                        in0_q  <= rd0;
                        in1_q  <= rd1;
                        in2_q  <= rd2;
                    end
                end
                ST_FLUSH: begin
                    if (!last_res) begin
                        if (wd_expired) begin
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            wd_q <= wd_q + WW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Final result ends the row regardless of where it arrives.
            if (last_res) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
                in0_q   <= '0;
                in1_q   <= '0;
                in2_q   <= '0;
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign bus.s_ready  = s_ready_q;
    assign bus.core_en  = core_en_q;
    assign bus.core_dis = core_dis_q;
    assign bus.core_in0 = in0_q;
    assign bus.core_in1 = in1_q;
    assign bus.core_in2 = in2_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_s      = m_s_q;
    assign bus.m_d      = m_d_q;
    assign bus.m_idx    = m_idx_q;

endmodule

// File: tb/tb_cdf53_row_sequencer.sv
// Directed bench for cdf53_row_sequencer with a 2-cycle-latency core model.
module tb_cdf53_row_sequencer;
    import cdf53_pkg::*;

    localparam int L    = 16;
    localparam int DW   = 8;
    localparam int WD   = 16;
    localparam int HALF = L / 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic start  = 1'b0;
    logic busy, done, err;

    cdf53_row_sequencer_if #(.LENGTH(L), .DW(DW)) bus ();

    cdf53_row_sequencer #(.LENGTH(L), .DW(DW), .WD_MAX(WD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    // Monitor state
    int en_cnt = 0, dis_cnt = 0, done_cnt = 0, hs_cnt = 0, bad_in_cnt = 0;
    int en_cyc = -1, dis_cyc = -1, done_cyc = -1;
    int mv_n = 0, pr_n = 0;
    int mv_idx [256], mv_s [256], mv_d [256], mv_cyc [256];
    int pr0 [256], pr1 [256], pr2 [256], pr_cyc [256];
    logic busy_at [4096];
    logic err_at  [4096];

    // Core model state
    int res_limit = HALF;
    int pair_left = 0, row_emit = 0;
    bit st0_v = 0, st1_v = 0;
    logic [7:0] st0_s = 0, st0_d = 0, st1_s = 0, st1_d = 0;

    // Monitor plus core model: result for a pair shown in cycle t is driven in t+2.
    always @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.core_result = 1'b0;
            bus.core_out_s  = '0;
            bus.core_out_d  = '0;
            st0_v = 0; st1_v = 0; pair_left = 0;
        end else begin
            busy_at[cyc % 4096] = busy;
            err_at[cyc % 4096]  = err;
            if (bus.s_valid && bus.s_ready) hs_cnt++;
            if (bus.core_en) begin en_cnt++; en_cyc = cyc; pair_left = HALF; row_emit = 0; end
            if (bus.core_dis) begin dis_cnt++; dis_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (bus.m_valid && mv_n < 256) begin
                mv_idx[mv_n] = int'(bus.m_idx); mv_s[mv_n] = int'(bus.m_s);
                mv_d[mv_n] = int'(bus.m_d); mv_cyc[mv_n] = cyc; mv_n++;
            end
            bus.core_result = st1_v && (row_emit < res_limit);
            bus.core_out_s  = st1_s;
            bus.core_out_d  = st1_d;
            if (bus.core_result) row_emit++;
            st1_v = st0_v; st1_s = st0_s; st1_d = st0_d;
            if (pair_left > 0) begin
                if (pr_n < 256) begin
                    pr0[pr_n] = int'(bus.core_in0); pr1[pr_n] = int'(bus.core_in1);
                    pr2[pr_n] = int'(bus.core_in2); pr_cyc[pr_n] = cyc; pr_n++;
                end
                st0_v = 1;
                st0_s = 8'(bus.core_in0 + bus.core_in2);
                st0_d = bus.core_in1 ^ 8'hA5;
                pair_left--;
            end else begin
                st0_v = 0;
                if ((bus.core_in0 | bus.core_in1 | bus.core_in2) != 0) bad_in_cnt++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Feed LENGTH samples base+n; toggle inserts a gap after each beat; extra
    // holds s_valid high afterwards to show no further accepts.
    task automatic load_row(input bit toggle, input int base, input int extra, output int last_acc);
        int n = 0;
        int g = 0;
        last_acc = -1;
        while (n < L && g < 4 * L) begin
            if (toggle && (g % 2 == 1)) begin
                bus.s_valid = 1'b0; bus.s_data = 8'hEE;
            end else begin
                bus.s_valid = 1'b1; bus.s_data = 8'(base + n);
            end
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) begin n++; last_acc = cyc; end
            @(posedge clk); #1;
            g++;
        end
        bus.s_valid = 1'b1; bus.s_data = 8'hEE;
        repeat (extra) begin @(posedge clk); #1; end
        bus.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_vec++;
        if ({busy, done, err, bus.s_ready, bus.core_en, bus.core_dis, bus.m_valid} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy, done, err, bus.s_ready, bus.core_en, bus.core_dis, bus.m_valid});
        end
        n_vec++;
        if ({bus.core_in0, bus.core_in1, bus.core_in2, bus.m_s, bus.m_d, bus.m_idx} !== 44'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0",
                     {bus.core_in0, bus.core_in1, bus.core_in2, bus.m_s, bus.m_d, bus.m_idx});
        end
        resetn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_ramp_row();
        int e0, m0, p0, d0, di0, b0, la, ex0, ex1, ex2, t0;
        res_limit = HALF;
        e0 = en_cnt; m0 = mv_n; p0 = pr_n; d0 = done_cnt; di0 = dis_cnt; b0 = bad_in_cnt;
        pulse_start();
        load_row(1'b0, 0, 0, la);
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
        repeat (2) tick();
        t0 = en_cyc;
        n_vec++;
        if (en_cnt - e0 != 1) begin n_err++; $display("FAIL ramp_core_en_count: got %0d want 1", en_cnt - e0); end
        n_vec++;
        if (pr_n - p0 != HALF) begin n_err++; $display("FAIL ramp_pair_count: got %0d want %0d", pr_n - p0, HALF); end
        for (int k = 0; k < HALF; k++) begin
            ex0 = 2 * k; ex1 = 2 * k + 1; ex2 = (k == HALF - 1) ? L - 1 : 2 * k + 2;
            n_vec++;
            if (pr0[p0+k] != ex0 || pr1[p0+k] != ex1 || pr2[p0+k] != ex2 || pr_cyc[p0+k] != t0 + k) begin
                n_err++;
                $display("FAIL ramp_pair%0d: got (%0d,%0d,%0d)@%0d want (%0d,%0d,%0d)@%0d", k,
                         pr0[p0+k], pr1[p0+k], pr2[p0+k], pr_cyc[p0+k], ex0, ex1, ex2, t0 + k);
            end
        end
        n_vec++;
        if (dis_cnt - di0 != 1 || dis_cyc != t0 + HALF) begin
            n_err++; $display("FAIL ramp_core_dis: got n=%0d @%0d want n=1 @%0d", dis_cnt - di0, dis_cyc, t0 + HALF);
        end
        n_vec++;
        if (mv_n - m0 != HALF) begin n_err++; $display("FAIL ramp_result_count: got %0d want %0d", mv_n - m0, HALF); end
        for (int k = 0; k < HALF; k++) begin
            ex0 = 2 * k; ex1 = 2 * k + 1; ex2 = (k == HALF - 1) ? L - 1 : 2 * k + 2;
            n_vec++;
            if (mv_idx[m0+k] != k || mv_s[m0+k] != ((ex0 + ex2) & 255) || mv_d[m0+k] != (ex1 ^ 'hA5)
                || mv_cyc[m0+k] != t0 + CORE_LAT + 1 + k) begin
                n_err++;
                $display("FAIL ramp_result%0d: got idx=%0d s=%0d d=%0d @%0d want idx=%0d s=%0d d=%0d @%0d", k,
                         mv_idx[m0+k], mv_s[m0+k], mv_d[m0+k], mv_cyc[m0+k],
                         k, (ex0 + ex2) & 255, ex1 ^ 'hA5, t0 + CORE_LAT + 1 + k);
            end
        end
        n_vec++;
        if (done_cnt - d0 != 1 || done_cyc != t0 + CORE_LAT + HALF) begin
            n_err++; $display("FAIL ramp_done: got n=%0d @%0d want n=1 @%0d", done_cnt - d0, done_cyc, t0 + CORE_LAT + HALF);
        end
        n_vec++;
        if (busy_at[done_cyc % 4096] !== 1'b1 || busy_at[(done_cyc + 1) % 4096] !== 1'b0) begin
            n_err++; $display("FAIL ramp_busy_tail: got %b%b want 10",
                              busy_at[done_cyc % 4096], busy_at[(done_cyc + 1) % 4096]);
        end
        n_vec++;
        if (bad_in_cnt != b0 || err !== 1'b0) begin
            n_err++; $display("FAIL ramp_idle_inputs_err: got stray=%0d err=%b want 0 0", bad_in_cnt - b0, err);
        end
    endtask

    task automatic test_toggle_load();
        int h0, m0, p0, d0, la, ok;
        res_limit = HALF;
        h0 = hs_cnt; m0 = mv_n; p0 = pr_n; d0 = done_cnt;
        pulse_start();
        load_row(1'b1, 'h20, 3, la);
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
        repeat (2) tick();
        n_vec++;
        if (hs_cnt - h0 != L) begin n_err++; $display("FAIL toggle_accepts: got %0d want %0d", hs_cnt - h0, L); end
        n_vec++;
        if (en_cyc != la + 1) begin n_err++; $display("FAIL toggle_run_start: got %0d want %0d", en_cyc, la + 1); end
        ok = 1;
        for (int k = 0; k < HALF; k++) begin
            if (pr0[p0+k] != 'h20 + 2 * k || pr1[p0+k] != 'h21 + 2 * k
                || pr2[p0+k] != ((k == HALF - 1) ? 'h20 + L - 1 : 'h22 + 2 * k)) ok = 0;
        end
        n_vec++;
        if (ok != 1) begin n_err++; $display("FAIL toggle_pairs: got mismatching data, first (%0d,%0d,%0d) want (32,33,34)", pr0[p0], pr1[p0], pr2[p0]); end
        n_vec++;
        if (mv_n - m0 != HALF || done_cnt - d0 != 1) begin
            n_err++; $display("FAIL toggle_completion: got results=%0d done=%0d want %0d 1", mv_n - m0, done_cnt - d0, HALF);
        end
    endtask

    task automatic test_watchdog();
        int m0, d0, la, t0;
        res_limit = HALF - 1;
        m0 = mv_n; d0 = done_cnt;
        pulse_start();
        load_row(1'b0, 'h50, 0, la);
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
        t0 = en_cyc;
        n_vec++;
        if (done_cnt - d0 != 1 || done_cyc != t0 + HALF + WD) begin
            n_err++; $display("FAIL wd_done: got n=%0d @%0d want n=1 @%0d", done_cnt - d0, done_cyc, t0 + HALF + WD);
        end
        n_vec++;
        if (err_at[done_cyc % 4096] !== 1'b1) begin n_err++; $display("FAIL wd_err_set: got %b want 1", err_at[done_cyc % 4096]); end
        n_vec++;
        if (mv_n - m0 != HALF - 1 || mv_idx[mv_n - 1] != HALF - 2) begin
            n_err++; $display("FAIL wd_results: got n=%0d last=%0d want %0d %0d", mv_n - m0, mv_idx[mv_n - 1], HALF - 1, HALF - 2);
        end
        repeat (5) tick();
        n_vec++;
        if (err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL wd_err_sticky: got err=%b busy=%b want 1 0", err, busy); end
        res_limit = HALF;
        d0 = done_cnt; m0 = mv_n;
        pulse_start();
        tick();
        n_vec++;
        if (err !== 1'b0 || bus.s_ready !== 1'b1) begin n_err++; $display("FAIL wd_err_clear: got err=%b s_ready=%b want 0 1", err, bus.s_ready); end
        load_row(1'b0, 'h70, 0, la);
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
        tick();
        n_vec++;
        if (err !== 1'b0 || mv_n - m0 != HALF) begin n_err++; $display("FAIL wd_recover: got err=%b results=%0d want 0 %0d", err, mv_n - m0, HALF); end
    endtask

    task automatic test_reset_mid_row();
        int d0, e0, m0, la, ok;
        res_limit = HALF;
        d0 = done_cnt; e0 = en_cnt;
        pulse_start();
        load_row(1'b0, 'h10, 0, la);
        for (int i = 0; i < 50 && en_cnt == e0; i++) tick();
        for (int i = 0; i < 50 && cyc < en_cyc + 3; i++) tick();
        #1 resetn = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, err, bus.s_ready, bus.core_en, bus.core_dis, bus.m_valid} !== 7'b0
            || {bus.core_in0, bus.core_in1, bus.core_in2, bus.m_s, bus.m_d, bus.m_idx} !== 44'h0) begin
            n_err++;
            $display("FAIL midrow_reset_outputs: got ctrl=%b data=%h want 0 0",
                     {busy, done, err, bus.s_ready, bus.core_en, bus.core_dis, bus.m_valid},
                     {bus.core_in0, bus.core_in1, bus.core_in2, bus.m_s, bus.m_d, bus.m_idx});
        end
        tick();
        resetn = 1'b1;
        repeat (20) tick();
        n_vec++;
        if (done_cnt != d0 || busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            n_err++; $display("FAIL midrow_no_done: got done=%0d busy=%b s_ready=%b want 0 0 0", done_cnt - d0, busy, bus.s_ready);
        end
        e0 = en_cnt; m0 = mv_n;
        pulse_start();
        load_row(1'b0, 'h60, 0, la);
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
        tick();
        ok = (mv_n - m0 == HALF) ? 1 : 0;
        for (int k = 0; k < HALF && ok == 1; k++) begin
            if (mv_idx[m0+k] != k || mv_s[m0+k] != (('h60 + 2 * k + ((k == HALF - 1) ? 'h60 + L - 1 : 'h62 + 2 * k)) & 255)
                || mv_d[m0+k] != (('h61 + 2 * k) ^ 'hA5)) ok = 0;
        end
        n_vec++;
        if (ok != 1 || done_cnt - d0 != 1 || en_cnt - e0 != 1) begin
            n_err++; $display("FAIL midrow_clean_row: got ok=%0d results=%0d done=%0d want 1 %0d 1", ok, mv_n - m0, done_cnt - d0, HALF);
        end
    endtask

    task automatic test_start_in_run();
        int d0, e0, m0, la;
        res_limit = HALF;
        d0 = done_cnt; e0 = en_cnt; m0 = mv_n;
        pulse_start();
        load_row(1'b0, 'h30, 0, la);
        for (int i = 0; i < 50 && en_cnt == e0; i++) tick();
        for (int i = 0; i < 50 && cyc < en_cyc + 2; i++) tick();
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
        repeat (4) tick();
        n_vec++;
        if (en_cnt - e0 != 1 || mv_n - m0 != HALF || done_cnt - d0 != 1) begin
            n_err++; $display("FAIL run_start_ignored: got en=%0d results=%0d done=%0d want 1 %0d 1",
                              en_cnt - e0, mv_n - m0, done_cnt - d0, HALF);
        end
        n_vec++;
        if (busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            n_err++; $display("FAIL run_start_no_restart: got busy=%b s_ready=%b want 0 0", busy, bus.s_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_ramp_row();
        test_toggle_load();
        test_watchdog();
        test_reset_mid_row();
        test_start_in_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdf53_row_sequencer.md
CDF53_ROW_SEQUENCER -- requirements
Module: cdf53_row_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  LENGTH  16  samples per row; even, >= 4
  DW      8   sample width
  WD_MAX  16  flush watchdog limit, cycles
REQ-002 Ports, one per line: name  direction  width  meaning.
  clk          in   1            single clock, rising edge
  resetn       in   1            asynchronous active-low reset
  start        in   1            begin one row (IDLE only)
  busy         out  1            high in LOAD/RUN/FLUSH
  done         out  1            one-cycle pulse at row end
  err          out  1            sticky watchdog error
  s_valid      in   1            input sample valid
  s_ready      out  1            high in LOAD only
  s_data       in   DW           input sample
  core_en      out  1            first-pair strobe to cdf5_3
  core_dis     out  1            end-of-row strobe to cdf5_3
  core_in0     out  DW           even sample x[2k]
  core_in1     out  DW           odd sample x[2k+1]
  core_in2     out  DW           next even sample
  core_out_s   in   DW           core low-band result
  core_out_d   in   DW           core high-band result
  core_result  in   1            core result-valid
  m_valid      out  1            output pair valid, no backpressure
  m_s          out  DW           low-band coefficient
  m_d          out  DW           high-band coefficient
  m_idx        out  $clog2(LENGTH)  coefficient pair index 0..LENGTH/2-1
REQ-003 One clock domain; resetn asynchronous assert, active-low, applied to every flop.

Function
REQ-004 States: IDLE, LOAD, RUN, FLUSH; encoding in package enum.
REQ-005 IDLE: start=1 -> LOAD next cycle, err cleared; start outside IDLE ignored.
REQ-006 LOAD: s_ready=1; each s_valid&s_ready writes s_data to buf[wr_cnt], wr_cnt++; LENGTH-th accept -> RUN next cycle; s_valid gaps stall with no timeout.
REQ-007 RUN: LENGTH/2 consecutive cycles k=0..LENGTH/2-1; registered core_in0=buf[2k], core_in1=buf[2k+1], core_in2=buf[2k+2]; for k=LENGTH/2-1, core_in2=buf[LENGTH-1] (right-edge replication).
REQ-008 core_en=1 only in the cycle pair 0 is presented; core_dis=1 only the single cycle after the last pair; both 0 otherwise.
REQ-009 Outside RUN, core_in0/1/2 driven 0.
REQ-010 RUN -> FLUSH after the last pair; FLUSH lasts until LENGTH/2 results are collected.
REQ-011 In RUN/FLUSH, core_result=1 -> next cycle m_valid=1, m_s/m_d = registered core_out_s/core_out_d, m_idx = collected count (0-based), then count++; core_result ignored in IDLE/LOAD.
REQ-012 Expected core latency is 2 cycles from pair to result; the sequencer does not rely on it, only counts core_result.
REQ-013 Collection of the LENGTH/2-th pair: done pulses in the same cycle as its m_valid; state -> IDLE.
REQ-014 FLUSH watchdog: WD_MAX cycles in FLUSH without completion -> err=1 (sticky until next accepted start), done pulse, -> IDLE.
REQ-015 Counters sized $clog2(LENGTH)+1; no wrap during a row.

Reset
REQ-016 resetn=0: state IDLE; busy, done, err, s_ready, core_en, core_dis, m_valid=0; core_in*, m_s, m_d, m_idx=0; counters 0; buf contents undefined.
REQ-017 Reset mid-row aborts the row; no done pulse; a fresh start is required afterwards.

Structure
REQ-018 Package cdf53_pkg: state enum, DW default, CORE_LAT=2 constant.
REQ-019 One sub-module, cdf53_row_buf: LENGTH x DW register file, one write port, three combinational read ports.
REQ-020 The cdf5_3 core is instantiated outside; the sequencer drives its ports only.

Verification
REQ-021 Load ramp x[i]=i, LENGTH=16 -> pairs (0,1,2)..(12,13,14), then (14,15,15); core_en with the first pair only; core_dis one cycle after (14,15,15).
REQ-022 Core model returning results 2 cycles after each pair -> m_idx 0..7 consecutive; done coincident with m_idx=7; busy drops next cycle.
REQ-023 s_valid toggling 1/0 during LOAD -> exactly 16 accepts; RUN starts one cycle after the 16th.
REQ-024 Core model returning only 7 results -> err=1 and done after 16 FLUSH cycles; next start clears err.
REQ-025 resetn pulsed low in RUN at k=3 -> all outputs 0 immediately; no done; a new start runs a clean row.
REQ-026 start asserted during RUN -> ignored; core_en count stays 1 for the row.
